// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and port-select values.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic SEL_M0 = 1'b0;
    localparam logic SEL_M1 = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: on contention the requester that did
// not win last time gets the grant.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic win,
    output logic any
);

    assign any = req0 | req1;
    assign win = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mux2t1_32.sv
// 32-bit 2:1 mux used to steer requester address/data onto the memory port.
module MUX2T1_32 (
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    input  logic        s,
    output logic [31:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (m0) and data access (m1)
// with round-robin grants and a bounded wait on the memory acknowledge.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          err,
    output logic          sel,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    state_t        state;
    logic          last;
    logic [CW-1:0] cnt;
    logic          win;
    logic          any;
    logic [AW-1:0] a0_q;
    logic [AW-1:0] a1_q;
    logic [DW-1:0] wd_q;
    logic          done_now;

    rr_pick2 u_pick (
        .req0 (m0_req),
        .req1 (m1_req),
        .last (last),
        .win  (win),
        .any  (any)
    );

    // Each requester keeps its own latched fields; the registered sel picks
    // which set reaches the port, so mem_* only change when the grant does.
    MUX2T1_32 u_addr_mux (
        .d0 (a0_q),
        .d1 (a1_q),
        .s  (sel),
        .y  (mem_addr)
    );

    MUX2T1_32 u_wdata_mux (
        .d0 (32'd0),
        .d1 (wd_q),
        .s  (sel),
        .y  (mem_wdata)
    );

    assign done_now = mem_ack || (cnt == CW'(WAIT_MAX - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            last     <= SEL_M1;
            sel      <= SEL_M0;
            cnt      <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            a0_q     <= '0;
            a1_q     <= '0;
            wd_q     <= '0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            err      <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        sel     <= win;
                        last    <= win;
                        cnt     <= '0;
                        mem_req <= 1'b1;
                        mem_we  <= (win == SEL_M1) && m1_we;
                        if (win == SEL_M1) begin
                            a1_q <= m1_addr;
                            wd_q <= m1_wdata;
                        end else begin
                            a0_q <= m0_addr;
                        end
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done_now) begin
                        // A timeout completes like an ack but with err set and no data.
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err     <= !mem_ack;
                        if (sel == SEL_M1) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= mem_ack ? mem_rdata : '0;
                        end
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    m0_ack   <= 1'b0;
                    m1_ack   <= 1'b0;
                    err      <= 1'b0;
                    m0_rdata <= '0;
                    m1_rdata <= '0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: masters and memory are bench agents; a transaction timeline
// model predicts every port value cycle by cycle.
module tb_mem_port_arbiter;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0;
    logic [31:0] m0_addr = '0;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0;
    logic        m1_we = 1'b0;
    logic [31:0] m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        err;
    logic        sel;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .WAIT_MAX(WAIT_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .err       (err),
        .sel       (sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    int n_chk = 0;
    int n_fail = 0;
    int c = 0;

    // Current transaction timeline: granted from inputs of cycle g, mem_req in
    // cycles g+1..g+L, owner ack in cycle g+L+1, next grant from cycle g+L+2.
    bit          have_txn = 1'b0;
    int          g, d, L;
    bit          t_own, t_we;
    logic [31:0] t_addr, t_wdata, t_rdata;
    bit          ref_last = 1'b1;
    int          free_from = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, c);
        end
    endtask

    function automatic bit in_busy(input int cc);
        return have_txn && cc >= g + 1 && cc <= g + L;
    endfunction

    function automatic bit is_ack(input int cc);
        return have_txn && cc == g + L + 1;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_m0_ack"}, m0_ack, 0);
        chk({tag, "_m1_ack"}, m1_ack, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_m0_rdata"}, m0_rdata, 0);
        chk({tag, "_m1_rdata"}, m1_rdata, 0);
    endtask

    task automatic check_cycle();
        bit busy, ak, e;
        busy = in_busy(c);
        ak   = is_ack(c);
        e    = ak && (d >= WAIT_MAX);
        chk("mem_req", mem_req, busy);
        if (busy) begin
            chk("sel", sel, t_own);
            chk("mem_addr", mem_addr, t_addr);
            chk("mem_we", mem_we, t_we);
            chk("mem_wdata", mem_wdata, t_wdata);
        end
        if (ak) chk("sel_at_ack", sel, t_own);
        chk("m0_ack", m0_ack, ak && !t_own);
        chk("m1_ack", m1_ack, ak && t_own);
        chk("err", err, e);
        chk("m0_rdata", m0_rdata, (ak && !t_own && !e) ? t_rdata : 32'd0);
        chk("m1_rdata", m1_rdata, (ak && t_own && !e && !t_we) ? t_rdata : 32'd0);
    endtask

    task automatic drive_cycle();
        bit ak, busy, win;
        ak   = is_ack(c);
        busy = in_busy(c);
        // Masters: hold until ack (sometimes beyond), occasionally abandon mid-access.
        if (m0_req) begin
            if (ak && !t_own) m0_req = ($urandom_range(3) == 0);
            else if (busy && !t_own && $urandom_range(7) == 0) m0_req = 1'b0;
        end else if ($urandom_range(2) == 0) begin
            m0_req  = 1'b1;
            m0_addr = $urandom;
        end
        if (m1_req) begin
            if (ak && t_own) m1_req = ($urandom_range(3) == 0);
            else if (busy && t_own && $urandom_range(7) == 0) m1_req = 1'b0;
        end else if ($urandom_range(2) == 0) begin
            m1_req   = 1'b1;
            m1_we    = $urandom_range(1);
            m1_addr  = $urandom;
            m1_wdata = $urandom;
        end
        // Grant decided by the reqs seen at the next edge, if the port is free.
        if (c >= free_from && (m0_req || m1_req)) begin
            win       = (m0_req && m1_req) ? !ref_last : m1_req;
            ref_last  = win;
            have_txn  = 1'b1;
            g         = c;
            d         = ($urandom_range(3) == 0) ? 0 : $urandom_range(WAIT_MAX + 3);
            L         = (d < WAIT_MAX) ? d + 1 : WAIT_MAX;
            t_own     = win;
            t_we      = win ? m1_we : 1'b0;
            t_addr    = win ? m1_addr : m0_addr;
            t_wdata   = win ? m1_wdata : 32'd0;
            free_from = g + L + 2;
        end
        // Memory: ack on the chosen wait, random noise whenever the port is not busy.
        mem_rdata = $urandom;
        if (in_busy(c)) mem_ack = (d < WAIT_MAX) && (c == g + 1 + d);
        else            mem_ack = ($urandom_range(4) == 0);
        if (in_busy(c) && c == g + L) t_rdata = mem_rdata;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            c++;
            check_cycle();
            drive_cycle();
        end
    endtask

    initial begin
        int guard;
        repeat (2) begin
            @(posedge clk);
            #1;
            c++;
            chk_zero("reset");
        end
        rst = 1'b0;
        free_from = c;
        drive_cycle();
        run(1500);

        guard = 0;
        while (!in_busy(c) && guard < 200) begin
            run(1);
            guard++;
        end
        chk("found_busy", in_busy(c), 1);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        repeat (2) begin
            @(posedge clk);
            #1;
            c++;
            chk_zero("in_rst");
        end
        // Both pending at release: first contended grant must go to m0.
        if (!m0_req) m0_addr = $urandom;
        if (!m1_req) begin
            m1_we    = $urandom_range(1);
            m1_addr  = $urandom;
            m1_wdata = $urandom;
        end
        m0_req    = 1'b1;
        m1_req    = 1'b1;
        have_txn  = 1'b0;
        ref_last  = 1'b1;
        free_from = c;
        rst       = 1'b0;
        drive_cycle();
        chk("grant_after_rst", t_own, 0);
        run(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
